// File: rtl/nyancat_frame_ctrl.sv
// nyancat_frame_ctrl: sequences animation frames on vsync ticks and handles play/pause/step/divider commands.
module nyancat_frame_ctrl #(
  parameter int NUM_FRAMES   = 12,
  parameter int DEFAULT_DIV  = 6,
  parameter int FRAME_ADDR_W = 16
) (
  input  logic                    px_clk,
  input  logic                    reset_n,
  input  logic                    vsync_tick,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [7:0]              cmd_arg,
  output logic [3:0]              frame_index,
  output logic [FRAME_ADDR_W-1:0] frame_base,
  output logic                    frame_adv,
  output logic                    playing
);
  localparam logic [1:0] OP_PLAY = 2'd0, OP_PAUSE = 2'd1, OP_STEP = 2'd2, OP_SET_DIV = 2'd3;
  typedef enum logic [1:0] {PAUSED, PLAYING, STEP_PEND} state_e;
  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] div_q, div_d, cnt_q, cnt_d;
  logic       adv_d, adv_q, ready_q, playing_q, xfer;
  // The tick is judged against the pre-command state; commands only steer the next state.
  always_comb begin
    xfer    = cmd_valid && ready_q;
    adv_d   = vsync_tick && ((state_q == PLAYING && cnt_q >= div_q - 8'd1) || state_q == STEP_PEND);
    idx_d   = adv_d ? (idx_q == 4'(NUM_FRAMES - 1) ? 4'd0 : idx_q + 4'd1) : idx_q;
    cnt_d   = (vsync_tick && state_q != PAUSED) ? (adv_d ? 8'd0 : cnt_q + 8'd1) : cnt_q;
    state_d = (vsync_tick && state_q == STEP_PEND) ? PAUSED : state_q;
    div_d   = div_q;
    if (xfer) begin
      if (cmd_op == OP_PLAY && state_q == PAUSED) begin
        state_d = PLAYING;
        cnt_d   = 8'd0;
      end
      if (cmd_op == OP_PAUSE && state_q == PLAYING) state_d = PAUSED;
      if (cmd_op == OP_STEP && state_q == PAUSED) state_d = STEP_PEND;
      if (cmd_op == OP_SET_DIV) div_d = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
    end
  end
  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      state_q   <= PLAYING;
      idx_q     <= 4'd0;
      adv_q     <= 1'b0;
      div_q     <= 8'(DEFAULT_DIV);
      cnt_q     <= 8'd0;
      ready_q   <= 1'b1;
      playing_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      adv_q     <= adv_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ready_q   <= state_d != STEP_PEND;
      playing_q <= state_d == PLAYING;
    end
  end
  assign cmd_ready   = ready_q;
  assign playing     = playing_q;
  assign frame_index = idx_q;
  assign frame_adv   = adv_q;
  assign frame_base  = FRAME_ADDR_W'(idx_q) << 12;
endmodule

// File: tb/tb_nyancat_frame_ctrl.sv
// tb_nyancat_frame_ctrl: directed vectors with hand-computed expectations for nyancat_frame_ctrl.
module tb_nyancat_frame_ctrl;
  logic        px_clk = 1'b0, reset_n = 1'b0, vsync_tick = 1'b0, cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_arg = 8'd0;
  logic        cmd_ready, frame_adv, playing;
  logic [3:0]  frame_index;
  logic [15:0] frame_base;
  int          total = 0, bad = 0;
  logic        live = 1'b0;
  nyancat_frame_ctrl dut (
    .px_clk(px_clk), .reset_n(reset_n), .vsync_tick(vsync_tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg), .frame_index(frame_index),
    .frame_base(frame_base), .frame_adv(frame_adv), .playing(playing)
  );
  always #5 px_clk = ~px_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge px_clk) if (live) begin
    chk("base", 32'(frame_base), 32'({frame_index, 12'h000}));
    chk("range", 32'(frame_index < 4'd12), 32'd1);
  end
  task automatic cyc(input logic tk, input logic v, input logic [1:0] op, input logic [7:0] arg);
    vsync_tick = tk;
    cmd_valid  = v;
    cmd_op     = op;
    cmd_arg    = arg;
    @(posedge px_clk);
    #1;
    vsync_tick = 1'b0;
    cmd_valid  = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 8'd0);
  endtask
  task automatic st(input string tag, input int fi, input int adv, input int pl, input int rdy);
    chk({tag, ".idx"}, 32'(frame_index), fi);
    chk({tag, ".adv"}, 32'(frame_adv), adv);
    chk({tag, ".play"}, 32'(playing), pl);
    chk({tag, ".rdy"}, 32'(cmd_ready), rdy);
  endtask
  initial begin
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    live = 1'b1;
    st("reset", 0, 0, 1, 1);
    chk("reset.base", 32'(frame_base), 0);
    reset_n = 1'b1;
    ticks(5);
    st("tick5", 0, 0, 1, 1);
    ticks(1);
    st("tick6", 1, 1, 1, 1);
    cyc(1'b0, 1'b0, 2'd0, 8'd0);
    st("tick6.idle", 1, 0, 1, 1);
    ticks(60);
    st("tick66", 11, 1, 1, 1);
    ticks(6);
    st("tick72", 0, 1, 1, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'd0);
    st("play_in_play", 0, 0, 1, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'd0);
    st("step_in_play", 0, 0, 1, 1);
    cyc(1'b0, 1'b1, 2'd1, 8'd0);
    st("pause", 0, 0, 0, 1);
    ticks(20);
    st("paused20", 0, 0, 0, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'd0);
    st("step", 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 2'd0, 8'd0);
    st("step.wait", 0, 0, 0, 0);
    ticks(1);
    st("step.tick", 1, 1, 0, 1);
    cyc(1'b0, 1'b1, 2'd0, 8'd0);
    st("play", 1, 0, 1, 1);
    cyc(1'b0, 1'b1, 2'd3, 8'd0);
    ticks(1);
    st("div0.t1", 2, 1, 1, 1);
    ticks(1);
    st("div0.t2", 3, 1, 1, 1);
    cyc(1'b0, 1'b1, 2'd3, 8'd6);
    ticks(4);
    st("div6.t4", 3, 0, 1, 1);
    cyc(1'b0, 1'b1, 2'd3, 8'd2);
    ticks(1);
    st("div2.late", 4, 1, 1, 1);
    ticks(1);
    st("div2.t1", 4, 0, 1, 1);
    ticks(1);
    st("div2.t2", 5, 1, 1, 1);
    ticks(1);
    st("div2.t3", 5, 0, 1, 1);
    cyc(1'b1, 1'b1, 2'd1, 8'd0);
    st("pause_tick", 6, 1, 0, 1);
    ticks(20);
    st("pause_tick20", 6, 0, 0, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'd0);
    ticks(1);
    st("to7", 7, 1, 0, 1);
    cyc(1'b0, 1'b1, 2'd2, 8'd0);
    st("pend7", 7, 0, 0, 0);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 2'd1, 8'd0);
    st("rst_pend", 0, 0, 1, 1);
    reset_n = 1'b1;
    ticks(5);
    st("rst.div5", 0, 0, 1, 1);
    ticks(1);
    st("rst.div6", 1, 1, 1, 1);
    live = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nyancat_frame_ctrl.md
NYANCAT_FRAME_CTRL -- requirements
Module: nyancat_frame_ctrl

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 12: number of animation frames in frame ROM.
REQ-002 SHALL have parameter DEFAULT_DIV, default 6: vsync ticks per animation frame after reset.
REQ-003 SHALL have parameter FRAME_ADDR_W, default 16: width of the frame ROM base address.
REQ-004 SHALL have port px_clk  input  1  pixel clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous to px_clk, active-low.
REQ-006 SHALL have port vsync_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-007 SHALL have port cmd_valid  input  1  command request.
REQ-008 SHALL have port cmd_ready  output  1  command accept; a transfer occurs when cmd_valid && cmd_ready.
REQ-009 SHALL have port cmd_op  input  2  0=PLAY, 1=PAUSE, 2=STEP, 3=SET_DIV.
REQ-010 SHALL have port cmd_arg  input  8  divider value for SET_DIV; ignored otherwise.
REQ-011 SHALL have port frame_index  output  4  current frame number, range [0, NUM_FRAMES-1].
REQ-012 SHALL have port frame_base  output  FRAME_ADDR_W  frame_index × 4096 (frame_index << 12), zero-extended.
REQ-013 SHALL have port frame_adv  output  1  one-cycle pulse in the cycle frame_index takes its new value.
REQ-014 SHALL have port playing  output  1  high in PLAYING state.

Function
REQ-015 SHALL implement states PAUSED, PLAYING and STEP_PEND.
REQ-016 SHALL hold cmd_ready high in PAUSED and PLAYING, and low in STEP_PEND.
REQ-017 SHALL handle PLAY as follows: PAUSED -> PLAYING with div_cnt cleared; no effect in PLAYING.
REQ-018 SHALL handle PAUSE as follows: PLAYING -> PAUSED with div_cnt held; no effect in PAUSED.
REQ-019 SHALL handle STEP as follows: PAUSED -> STEP_PEND; accepted and ignored in PLAYING.
REQ-020 SHALL handle SET_DIV in any accepting state: div <= cmd_arg, with cmd_arg=0 stored as 1; state unchanged.
REQ-021 SHALL, on vsync_tick in PLAYING, advance when div_cnt >= div-1 (div_cnt cleared), else increment div_cnt.
REQ-022 SHALL, on vsync_tick in STEP_PEND, advance exactly once and go to PAUSED with div_cnt cleared.
REQ-023 SHALL ignore vsync_tick in PAUSED.
REQ-024 SHALL define advance as frame_index <= (frame_index == NUM_FRAMES-1) ? 0 : frame_index+1, with frame_adv=1 for that cycle only.
REQ-025 SHALL give an update latency of one clock: frame_index, frame_base and frame_adv change on the px_clk edge that samples vsync_tick high; frame_index never changes outside that edge.
REQ-026 SHALL, when a command transfer and vsync_tick occur in the same cycle, evaluate the tick against the pre-command state, div and div_cnt; the command takes effect from the next cycle.
REQ-027 SHALL, after SET_DIV to a value at or below the current div_cnt, advance on the next tick in PLAYING (>= compare).
REQ-028 SHALL keep div_cnt 8 bits wide and never let it exceed 254.
REQ-029 SHALL drive frame_base as a registered or direct function of frame_index only, with no extra latency.

Reset
REQ-030 SHALL, while reset_n=0 at a px_clk edge, set: state PLAYING, frame_index 0, frame_base 0, frame_adv 0, div DEFAULT_DIV, div_cnt 0, cmd_ready 1, playing 1.
REQ-031 SHALL let reset override any pending STEP, command transfer or vsync_tick in the same cycle.

Verification
REQ-032 SHALL be verified by: reset, 6 ticks -> frame_index=1, frame_adv pulses once on the 6th tick; 72 ticks total -> frame_index wraps 11->0.
REQ-033 SHALL be verified by: PAUSE, 20 ticks -> frame_index unchanged; STEP -> cmd_ready=0 until next tick, then frame_index+1, playing=0, cmd_ready=1.
REQ-034 SHALL be verified by: SET_DIV 0 -> advance on every tick; SET_DIV 2 issued at div_cnt=4 -> next tick advances.
REQ-035 SHALL be verified by: PAUSE in the same cycle as a terminal tick -> one advance, then frame_index held for 20 further ticks.
REQ-036 SHALL be verified by: reset_n=0 during STEP_PEND at frame_index=7 -> frame_index=0, playing=1, cmd_ready=1, div=6.
REQ-037 SHALL be verified by checking on every cycle: frame_base == frame_index<<12 and frame_index < NUM_FRAMES.
